i2c_tx_sr: RTL and testbench
============================

# i2c_tx_sr

Transmit-side shift engine for the I2C slave, the counterpart of the receive shift register. On a slave-read transfer it accepts a byte from the slave controller and drives it MSB-first onto SDA, changing data only after SCL falling edges. It then releases SDA for the master's acknowledge and samples that bit on the following SCL rising edge. It sits between the slave controller FSM and the SDA output driver, and consumes the same `rising_edge_found`/`falling_edge_found` pulses from the SCL edge detector that the receive path uses.

## Interface

Parameters:
- `NUM_BITS`, default 8: data width shifted per transfer; ACK slot follows bit `NUM_BITS-1`.

Ports:
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tx_enable` input 1: controller permits transmission; low aborts any transfer.
- `load_data` input 1: one-cycle pulse; latch `tx_data` and start a byte.
- `tx_data` input `NUM_BITS`: byte to send, MSB first.
- `falling_edge_found` input 1: one-cycle pulse, SCL fell (synchronized).
- `rising_edge_found` input 1: one-cycle pulse, SCL rose (synchronized).
- `sda_in` input 1: synchronized SDA, sampled for master ACK.
- `stop_found` input 1: one-cycle pulse, STOP condition detected.
- `sda_out` output 1: SDA drive value; 1 means released (open-drain high).
- `tx_busy` output 1: high in SHIFT or ACK_WAIT.
- `byte_done` output 1: one-cycle pulse when ACK slot sampled.
- `master_ack` output 1: registered ACK result, valid with and held after `byte_done`; 1 = ACK (SDA low), 0 = NACK.

## Operation

- States: IDLE, SHIFT, ACK_WAIT.
- **IDLE:** `sda_out`=1.
  - `load_data` & `tx_enable` latches `tx_data`, clears `bit_cnt` and moves to SHIFT.
  - `sda_out` presents `tx_data[NUM_BITS-1]` on the next cycle.
- **SHIFT:** `sda_out` = MSB of the shift register.
  - On `falling_edge_found` with `bit_cnt` < `NUM_BITS-1`: shift left, fill with 1, increment `bit_cnt`.
  - On `falling_edge_found` with `bit_cnt` = `NUM_BITS-1`: stay at `bit_cnt`, set `sda_out`=1 (release) and move to ACK_WAIT.
  - `rising_edge_found` is ignored in this state.
- **ACK_WAIT:** `sda_out`=1.
  - On `rising_edge_found`: `master_ack` ← ~`sda_in`, pulse `byte_done`, go to IDLE.
  - `falling_edge_found` is ignored in this state.
- **Abort:** `stop_found`, or `tx_enable` low, in any state returns to IDLE next cycle.
  - `sda_out`=1; no `byte_done`; `master_ack` unchanged.
  - Abort has priority over `load_data` and edge pulses in the same cycle.
- `load_data` while `tx_busy` is ignored; the byte in flight is unaffected.
- `bit_cnt` width is clog2(`NUM_BITS`); it never wraps. Terminal compare is `NUM_BITS-1`.

## Timing

- Reset values: state IDLE, shift register all 1s, `bit_cnt` 0, `sda_out` 1, `tx_busy` 0, `byte_done` 0, `master_ack` 0.
- All outputs are registered.
- `load_data` at cycle N gives `sda_out` = MSB and `tx_busy`=1 at N+1.
- `falling_edge_found` at cycle N changes `sda_out` at N+1.
- `rising_edge_found` in ACK_WAIT at cycle N gives `byte_done`=1 and valid `master_ack` at N+1, with `tx_busy`=0 at N+1.
- Controller may issue the next `load_data` in the same cycle `byte_done` is high; it is accepted, since state is IDLE.
- Reset mid-byte: immediate return to reset values, SDA released asynchronously.

## Structure

- Shared package `i2c_pkg`:
  - `tx_state_t` enum (IDLE, SHIFT, ACK_WAIT).
  - `I2C_BYTE_BITS` = 8, used as the `NUM_BITS` default.
  - `SDA_RELEASE` = 1'b1.
- Sub-module `flex_pts_sr`: parallel-to-serial shift register, the mirror of `flex_stp_sr`.
  - Parameters `NUM_BITS`, `SHIFT_MSB`=1.
  - Ports: `load_enable`, `shift_enable`, `parallel_in`, `serial_out`.
  - Asynchronous active-high reset to all 1s.
  - The FSM and bit counter live in `i2c_tx_sr`.

## Test plan

- Reset released, no stimulus → `sda_out`=1, `tx_busy`=0, `byte_done`=0 for 20 cycles.
- Load 0xA5, 8 falling edges, then rising with `sda_in`=0:
  - `sda_out` sequence is 1,0,1,0,0,1,0,1, then 1 (released).
  - `byte_done` pulses once; `master_ack`=1.
- Load 0x3C, ACK slot with `sda_in`=1 → `master_ack`=0 (NACK) and `byte_done` pulses; second load 0xFF in the same cycle as `byte_done` is accepted and transmits 0xFF.
- `stop_found` after bit 3 of 0x0F → `sda_out`=1 next cycle, state IDLE, no `byte_done`, `master_ack` holds its prior value.
- Second `load_data`=0x00 during SHIFT of 0x81 → ignored; transmitted sequence is 1,0,0,0,0,0,0,1.
- `rst` asserted asynchronously mid-byte between clock edges → `sda_out`=1 immediately; after release, a fresh load of 0x55 transmits correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: transmit FSM states, default byte width
// and the SDA level used to release the open-drain line.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        ACK_WAIT = 2'd2
    } tx_state_t;

    localparam int   I2C_BYTE_BITS = 8;
    localparam logic SDA_RELEASE   = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register, the transmit mirror of flex_stp_sr.
// Vacated positions fill with the released SDA level, so an idle or fully
// shifted register always presents 1s. serial_next exposes the bit that
// will reach serial_out after the next shift, which lets the owner keep its
// SDA drive fully registered. NUM_BITS must be at least 2.
module flex_pts_sr
    import i2c_pkg::*;
#(
    parameter int NUM_BITS  = I2C_BYTE_BITS,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_enable,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out,
    output logic                serial_next
);

    logic [NUM_BITS-1:0] r_data;

    // Load has priority over shift; the shift direction is fixed at elaboration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '1;
        end else if (load_enable) begin
            r_data <= parallel_in;
        end else if (shift_enable) begin
            if (SHIFT_MSB) begin
                r_data <= {r_data[NUM_BITS-2:0], SDA_RELEASE};
            end else begin
                r_data <= {SDA_RELEASE, r_data[NUM_BITS-1:1]};
            end
        end
    end

    assign serial_out  = SHIFT_MSB ? r_data[NUM_BITS-1] : r_data[0];
    assign serial_next = SHIFT_MSB ? r_data[NUM_BITS-2] : r_data[1];

endmodule

// File: rtl/i2c_tx_sr.sv
// Transmit-side shift engine for the I2C slave. Drives a loaded byte
// MSB-first onto SDA, changing data only after SCL falling edges, then
// releases SDA and samples the master's ACK on the next SCL rising edge.
// Every output comes straight from a flop so SDA never glitches.
module i2c_tx_sr
    import i2c_pkg::*;
#(
    parameter int NUM_BITS = I2C_BYTE_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_enable,
    input  logic                load_data,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                falling_edge_found,
    input  logic                rising_edge_found,
    input  logic                sda_in,
    input  logic                stop_found,
    output logic                sda_out,
    output logic                tx_busy,
    output logic                byte_done,
    output logic                master_ack
);

    localparam int              CNT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    tx_state_t        r_state;
    tx_state_t        w_next_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_next;
    logic             r_sda_out;
    logic             w_sda_next;
    logic             r_tx_busy;
    logic             r_byte_done;
    logic             w_done_next;
    logic             r_master_ack;
    logic             w_ack_next;
    logic             w_load;
    logic             w_shift;
    logic             w_abort;
    logic             w_serial_out;
    logic             w_serial_next;

    assign w_abort = stop_found | ~tx_enable;

    flex_pts_sr #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (1'b1)
    ) u_shift_reg (
        .clk          (clk),
        .rst          (rst),
        .load_enable  (w_load),
        .shift_enable (w_shift),
        .parallel_in  (tx_data),
        .serial_out   (w_serial_out),
        .serial_next  (w_serial_next)
    );

    // Next-state logic: abort wins over everything, then per-state edge handling.
    always_comb begin
        w_next_state   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_sda_next     = r_sda_out;
        w_done_next    = 1'b0;
        w_ack_next     = r_master_ack;
        w_load         = 1'b0;
        w_shift        = 1'b0;

        if (w_abort) begin
            w_next_state = IDLE;
            w_sda_next   = SDA_RELEASE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_sda_next = SDA_RELEASE;
                    if (load_data) begin
                        w_load         = 1'b1;
                        w_bit_cnt_next = '0;
                        w_next_state   = SHIFT;
                        w_sda_next     = tx_data[NUM_BITS-1];
                    end
                end
                SHIFT: begin
                    w_sda_next = w_serial_out;
                    if (falling_edge_found) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            w_next_state = ACK_WAIT;
                            w_sda_next   = SDA_RELEASE;
                        end else begin
                            w_shift        = 1'b1;
                            w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                            w_sda_next     = w_serial_next;
                        end
                    end
                end
                ACK_WAIT: begin
                    w_sda_next = SDA_RELEASE;
                    if (rising_edge_found) begin
                        w_ack_next   = ~sda_in;
                        w_done_next  = 1'b1;
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    w_sda_next   = SDA_RELEASE;
                end
            endcase
        end
    end

    // State, counter and output registers; reset releases SDA immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_sda_out    <= SDA_RELEASE;
            r_tx_busy    <= 1'b0;
            r_byte_done  <= 1'b0;
            r_master_ack <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_bit_cnt    <= w_bit_cnt_next;
            r_sda_out    <= w_sda_next;
            r_tx_busy    <= (w_next_state != IDLE);
            r_byte_done  <= w_done_next;
            r_master_ack <= w_ack_next;
        end
    end

    assign sda_out    = r_sda_out;
    assign tx_busy    = r_tx_busy;
    assign byte_done  = r_byte_done;
    assign master_ack = r_master_ack;

endmodule

// File: tb/tb_i2c_tx_sr.sv
// Directed bench for i2c_tx_sr: a vector table for complete transfers plus
// hand sequences for abort, ignored reload and asynchronous reset.
module tb_i2c_tx_sr;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_enable;
    logic       load_data;
    logic [7:0] tx_data;
    logic       falling_edge_found;
    logic       rising_edge_found;
    logic       sda_in;
    logic       stop_found;
    logic       sda_out;
    logic       tx_busy;
    logic       byte_done;
    logic       master_ack;

    int checks = 0;
    int passes = 0;
    logic modelAck;

    typedef struct {
        string      name;
        logic       load;
        logic [7:0] data;
        logic       fall;
        logic       rise;
        logic       sdaIn;
        logic       expSda;
        logic       expBusy;
        logic       expDone;
        logic       expAck;
    } vec_t;

    vec_t vecs[$];

    i2c_tx_sr #(.NUM_BITS(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_enable          (tx_enable),
        .load_data          (load_data),
        .tx_data            (tx_data),
        .falling_edge_found (falling_edge_found),
        .rising_edge_found  (rising_edge_found),
        .sda_in             (sda_in),
        .stop_found         (stop_found),
        .sda_out            (sda_out),
        .tx_busy            (tx_busy),
        .byte_done          (byte_done),
        .master_ack         (master_ack)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs from a falling edge, leave pulses low afterwards.
    task automatic applyStimulus(input logic load, input logic [7:0] data,
                                 input logic fall, input logic rise,
                                 input logic sdaIn, input logic stop);
        load_data          = load;
        tx_data            = data;
        falling_edge_found = fall;
        rising_edge_found  = rise;
        sda_in             = sdaIn;
        stop_found         = stop;
        @(negedge clk);
        load_data          = 1'b0;
        falling_edge_found = 1'b0;
        rising_edge_found  = 1'b0;
        stop_found         = 1'b0;
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic checkOutput(input string name, input logic s, input logic b,
                               input logic d, input logic a);
        checkBit({name, " sda_out"},    sda_out,    s);
        checkBit({name, " tx_busy"},    tx_busy,    b);
        checkBit({name, " byte_done"},  byte_done,  d);
        checkBit({name, " master_ack"}, master_ack, a);
    endtask

    function automatic vec_t mk(input string n, input logic l, input logic [7:0] d,
                                input logic f, input logic r, input logic si,
                                input logic es, input logic eb, input logic ed,
                                input logic ea);
        vec_t v;
        v.name = n; v.load = l; v.data = d; v.fall = f; v.rise = r; v.sdaIn = si;
        v.expSda = es; v.expBusy = eb; v.expDone = ed; v.expAck = ea;
        return v;
    endfunction

    // Full byte with per-bit checks, using the bench's own copy of the data.
    task automatic sendByte(input string name, input logic [7:0] data, input logic sdaIn);
        applyStimulus(1'b1, data, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput({name, " load"}, data[7], 1'b1, 1'b0, modelAck);
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("%s bit%0d", name, i), data[i], 1'b1, 1'b0, modelAck);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput({name, " release"}, 1'b1, 1'b1, 1'b0, modelAck);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, sdaIn, 1'b0);
        modelAck = ~sdaIn;
        checkOutput({name, " ack"}, 1'b1, 1'b0, 1'b1, modelAck);
    endtask

    initial begin
        rst = 1'b1; tx_enable = 1'b1; load_data = 1'b0; tx_data = 8'h00;
        falling_edge_found = 1'b0; rising_edge_found = 1'b0;
        sda_in = 1'b1; stop_found = 1'b0;
        modelAck = 1'b0;

        // A5 with ACK: 1,0,1,0,0,1,0,1 then release
        vecs.push_back(mk("A5 load", 1, 8'hA5, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("A5 b6",   0, 8'h00, 1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("A5 b5",   0, 8'h00, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("A5 b4",   0, 8'h00, 1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("A5 b3",   0, 8'h00, 1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("A5 b2",   0, 8'h00, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("A5 b1",   0, 8'h00, 1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("A5 b0",   0, 8'h00, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("A5 rel",  0, 8'h00, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("A5 ack",  0, 8'h00, 0, 1, 0, 1, 0, 1, 1));
        vecs.push_back(mk("A5 idle", 0, 8'h00, 0, 0, 1, 1, 0, 0, 1));
        // 3C with NACK, stray edges ignored, FF loaded alongside byte_done
        vecs.push_back(mk("3C load", 1, 8'h3C, 0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk("3C rise ignored", 0, 8'h00, 0, 1, 1, 0, 1, 0, 1));
        vecs.push_back(mk("3C b6",   0, 8'h00, 1, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk("3C b5",   0, 8'h00, 1, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk("3C b4",   0, 8'h00, 1, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk("3C b3",   0, 8'h00, 1, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk("3C b2",   0, 8'h00, 1, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk("3C b1",   0, 8'h00, 1, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk("3C b0",   0, 8'h00, 1, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk("3C rel",  0, 8'h00, 1, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk("3C fall ignored", 0, 8'h00, 1, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk("3C nack", 0, 8'h00, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk("FF load on done", 1, 8'hFF, 0, 0, 1, 1, 1, 0, 0));
        for (int i = 6; i >= 0; i--)
            vecs.push_back(mk($sformatf("FF b%0d", i), 0, 8'h00, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("FF rel",  0, 8'h00, 1, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("FF ack",  0, 8'h00, 0, 1, 0, 1, 0, 1, 1));
        vecs.push_back(mk("FF idle", 0, 8'h00, 0, 0, 1, 1, 0, 0, 1));

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Quiet line after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].load, vecs[i].data, vecs[i].fall, vecs[i].rise,
                          vecs[i].sdaIn, 1'b0);
            checkOutput(vecs[i].name, vecs[i].expSda, vecs[i].expBusy,
                        vecs[i].expDone, vecs[i].expAck);
        end
        modelAck = 1'b1;

        // STOP after bit 3 of 0x0F
        applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("0F load", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("0F b3", 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("0F stop", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("after stop fall", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("after stop rise", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("load with stop", 1'b1, 1'b0, 1'b0, 1'b1);

        // tx_enable low aborts and blocks loads
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("81 b6 pre-disable", 1'b0, 1'b1, 1'b0, 1'b1);
        tx_enable = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("disable abort", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("load while disabled", 1'b1, 1'b0, 1'b0, 1'b1);
        tx_enable = 1'b1;

        // Reload during SHIFT of 0x81 is ignored: 1,0,0,0,0,0,0,1
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("81 b7", 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("81 b6", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("81 reload ignored", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("81 b5", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("81 b4", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("81 b3", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("81 b2 with reload", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("81 b1", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("81 b0", 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("81 rel", 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        modelAck = 1'b0;
        checkOutput("81 nack", 1'b1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset while a 0 is on SDA
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("55 pre-reset", 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 checkOutput("async reset", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        modelAck = 1'b0;
        @(negedge clk);
        sendByte("55 fresh", 8'h55, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
